// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Owns the fetch PC and keeps at most one request outstanding to a
// variable-latency instruction memory. Returned words are tagged with their PC
// and held in a small FIFO that decode drains through a valid/ready handshake.
// A redirect flushes the FIFO, restarts fetch at the new PC and marks any
// in-flight request so its response is dropped.
//
// Optional feature: define FETCH_STALL_CNT_EN to build the decode-starved cycle
// counter on stall_cnt. Without it stall_cnt is tied to zero (same port list).
//
// Ports:
//   clk            system clock, all state on the rising edge
//   reset          synchronous active-low reset
//   imem_req       one-cycle request pulse to instruction memory
//   imem_addr      word address of the request (bits [1:0] always 0)
//   imem_rvalid    memory response valid
//   imem_rdata     memory response data
//   redirect_valid branch/jump taken: flush and restart
//   redirect_pc    restart address (bits [1:0] ignored)
//   instr_valid    FIFO head valid
//   instr_out      instruction at FIFO head
//   instr_pc       PC of instr_out
//   instr_ready    decode accepts the head entry
//   stall_cnt      cycles decode was ready but starved
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : (FIFO_DEPTH <= 4) ? 2 : 3;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // nothing outstanding
    ST_WAIT = 2'b01,  // request outstanding, response kept
    ST_DROP = 2'b10   // request outstanding, response discarded
  } state_t;

  state_t            state_r, state_next_s;
  logic [31:0]       fetch_pc_r, fetch_pc_next_s;
  logic [31:0]       req_pc_r;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [31:0]       data_mem_r [FIFO_DEPTH];
  logic [31:0]       pc_mem_r   [FIFO_DEPTH];
  logic              push_s, pop_s, slot_free_s, issue_s;
  logic              unused_s;

  // Circular pointer advance for a depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  // Low redirect bits are deliberately ignored.
  assign unused_s = ^redirect_pc[1:0];

  // Handshake, occupancy and issue decisions for this cycle.
  always_comb begin
    push_s      = (state_r == ST_WAIT) && imem_rvalid;
    pop_s       = (cnt_r != {CNT_W{1'b0}}) && instr_ready;
    cnt_next_s  = cnt_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    // The memory port frees up in the same cycle the response returns.
    slot_free_s = (state_r == ST_IDLE) || imem_rvalid;
    // Counting cnt_next reserves a FIFO slot for the request's response.
    issue_s     = reset && !redirect_valid && slot_free_s && (cnt_next_s < DEPTH_C);
  end

  // Next-state and next fetch PC; redirect overrides everything else.
  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    if (redirect_valid) begin
      fetch_pc_next_s = {redirect_pc[31:2], 2'b00};
      case (state_r)
        ST_WAIT: state_next_s = imem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state_next_s = imem_rvalid ? ST_IDLE : ST_DROP;
        ST_IDLE: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end else if (issue_s) begin
      state_next_s    = ST_WAIT;
      fetch_pc_next_s = fetch_pc_r + 32'd4;
    end else if ((state_r != ST_IDLE) && imem_rvalid) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  // Control state: FSM, fetch PC, request tag, FIFO count and pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= {RESET_PC[31:2], 2'b00};
      req_pc_r   <= 32'h0000_0000;
      cnt_r      <= {CNT_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      if (issue_s) begin
        req_pc_r <= fetch_pc_r;
      end
      if (redirect_valid) begin
        cnt_r    <= {CNT_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        cnt_r <= cnt_next_s;
        if (push_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
      end
    end
  end

  // FIFO storage; contents only matter while counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s && !redirect_valid) begin
      data_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
    end
  end

  assign imem_req    = issue_s;
  assign imem_addr   = fetch_pc_r;
  assign instr_valid = (cnt_r != {CNT_W{1'b0}});
  // Head is masked to zero when empty so outputs read as zero out of reset.
  assign instr_out   = instr_valid ? data_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign instr_pc    = instr_valid ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where decode was ready but had nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (instr_ready && !instr_valid && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'h0000_0000;
`endif

endmodule
